// File: rtl/xor_reduce_pkg.sv
// Shared types and sizing helpers for the serial XOR-reduction parity engine.
package xor_reduce_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      BUSY = 2'd1,
      DONE = 2'd2
   } state_e;

   // Number of LANES-wide chunks needed to cover a WIDTH-bit word.
   function automatic int n_chunks(input int width, input int lanes);
      return (width + lanes - 1) / lanes;
   endfunction

endpackage

// File: rtl/xor_reduce_serial_mux_xor2.sv
// Two-input XOR cell built from a single 2:1 mux: a selects between b and its inverse.
module mux_xor2 (
   input  logic a,
   input  logic b,
   output logic y
);

   logic b_n_s;

   assign b_n_s = ~b;
   assign y     = a ? b_n_s : b;

endmodule

// File: rtl/xor_reduce_serial.sv
// Multi-cycle parity engine: folds LANES bits per clock into an accumulator through
// a chain of mux-built XOR cells, with valid/ready handshakes on both sides.
module xor_reduce_serial
   import xor_reduce_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int LANES = 1,
   parameter int ODD   = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic             out_parity,
   output logic             busy
);

   localparam int   n_c     = n_chunks(WIDTH, LANES);
   localparam int   cnt_w_c = $clog2(n_c + 1);
   localparam int   shift_w_c = n_c * LANES;
   localparam logic odd_c   = (ODD != 0) ? 1'b1 : 1'b0;

   state_e                 state_r;
   state_e                 state_nx_s;
   logic                   acc_r;
   logic [cnt_w_c-1:0]     cnt_r;
   logic [shift_w_c-1:0]   shift_r;
   logic                   parity_r;
   logic [LANES:0]         chain_s;
   logic                   result_s;
   logic                   last_s;

   assign last_s     = (cnt_r == cnt_w_c'(1));
   assign chain_s[0] = acc_r;

   // Fold the low chunk of the shift register into the running accumulator.
   for (genvar i = 0; i < LANES; i++) begin : g_fold
      mux_xor2 u_cell (
         .a (shift_r[i]),
         .b (chain_s[i]),
         .y (chain_s[i+1])
      );
   end

   mux_xor2 u_odd (
      .a (odd_c),
      .b (chain_s[LANES]),
      .y (result_s)
   );

   // State register.
   always_ff @(posedge clk) begin
      if (!rst) begin
         state_r <= IDLE;
      end else begin
         state_r <= state_nx_s;
      end
   end

   // Next-state logic; in_ready is implicit in IDLE since rst is high here.
   always_comb begin
      state_nx_s = state_r;
      case (state_r)
         IDLE: begin
            if (in_valid) begin
               state_nx_s = BUSY;
            end else begin
               state_nx_s = IDLE;
            end
         end
         BUSY: begin
            if (last_s) begin
               state_nx_s = DONE;
            end else begin
               state_nx_s = BUSY;
            end
         end
         DONE: begin
            if (out_ready) begin
               state_nx_s = IDLE;
            end else begin
               state_nx_s = DONE;
            end
         end
         default: state_nx_s = IDLE;
      endcase
   end

   // Datapath: load on accept, shift and accumulate while busy, capture result on the last chunk.
   always_ff @(posedge clk) begin
      if (!rst) begin
         acc_r    <= 1'b0;
         cnt_r    <= {cnt_w_c{1'b0}};
         shift_r  <= {shift_w_c{1'b0}};
         parity_r <= 1'b0;
      end else begin
         case (state_r)
            IDLE: begin
               if (in_valid) begin
                  shift_r <= shift_w_c'(in_data);
                  acc_r   <= 1'b0;
                  cnt_r   <= cnt_w_c'(n_c);
               end
            end
            BUSY: begin
               acc_r   <= chain_s[LANES];
               shift_r <= shift_r >> LANES;
               cnt_r   <= cnt_r - cnt_w_c'(1);
               if (last_s) begin
                  parity_r <= result_s;
               end
            end
            DONE: begin
               parity_r <= parity_r;
            end
            default: begin
               acc_r <= 1'b0;
            end
         endcase
      end
   end

   // Handshake flags decode from the state register; reset holds in_ready low.
   always_comb begin
      in_ready  = 1'b0;
      busy      = 1'b0;
      out_valid = 1'b0;
      if (!rst) begin
         in_ready = 1'b0;
      end else begin
         in_ready = (state_r == IDLE);
      end
      busy      = (state_r == BUSY);
      out_valid = (state_r == DONE);
   end

   assign out_parity = parity_r;

endmodule
